// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter with a one-word holding buffer for zero-bubble streaming.
// Ports: clk, reset_i (sync, active-low), data_i/valid_i/ready_o in, bit_o/bit_valid_o/last_o out.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             bit_o,
  output logic             bit_valid_o,
  output logic             last_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             accept;
  logic             at_last;

  assign ready_o = reset_i & ~hold_full;
  assign accept  = valid_i & ready_o;
  assign at_last = (state == SHIFT) && (cnt == LAST);

  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted = {shreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign shifted = {1'b0, shreg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Staying in SHIFT at the last bit needs either a buffered or a fresh word.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept) state_nxt = SHIFT;
      SHIFT: if (at_last && !hold_full && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_i) begin
      cnt       <= '0;
      shreg     <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            shreg <= data_i;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          if (cnt == LAST) begin
            cnt <= '0;
            // Buffered word is older than anything on data_i.
            if (hold_full) begin
              shreg     <= hold_data;
              hold_full <= 1'b0;
            end else if (accept) begin
              shreg <= data_i;
            end else begin
              shreg <= '0;
            end
          end else begin
            shreg <= shifted;
            cnt   <= cnt + CW'(1);
            if (accept) begin
              hold_data <= data_i;
              hold_full <= 1'b1;
            end
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  // All outputs decode registered state only.
  always_comb begin
    bit_valid_o = (state == SHIFT);
    bit_o       = 1'b0;
    if (state == SHIFT) begin
      bit_o = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    end
    last_o = at_last;
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboarded bench for bit_serializer: three instances (4b MSB, 8b MSB, 8b LSB),
// expected bits queued at stimulus time and popped by per-instance monitors.
module tb_bit_serializer;

  logic       clk;
  logic       rst;
  logic [3:0] d4;
  logic       v4, ready4, bit4, bv4, last4;
  logic [7:0] d8;
  logic       v8, ready8, bit8, bv8, last8;
  logic [7:0] d8l;
  logic       v8l, ready8l, bit8l, bv8l, last8l;

  int checks;
  int errors;

  logic [1:0] q4[$];
  logic [1:0] q8[$];
  logic [1:0] q8l[$];

  bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u4 (
    .clk(clk), .reset_i(rst), .data_i(d4), .valid_i(v4),
    .ready_o(ready4), .bit_o(bit4), .bit_valid_o(bv4), .last_o(last4)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u8 (
    .clk(clk), .reset_i(rst), .data_i(d8), .valid_i(v8),
    .ready_o(ready8), .bit_o(bit8), .bit_valid_o(bv8), .last_o(last8)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u8l (
    .clk(clk), .reset_i(rst), .data_i(d8l), .valid_i(v8l),
    .ready_o(ready8l), .bit_o(bit8l), .bit_valid_o(bv8l), .last_o(last8l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push8(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) q8.push_back({w[i], i == 0});
  endtask

  task automatic push8l(input logic [7:0] w);
    for (int i = 0; i < 8; i++) q8l.push_back({w[i], i == 7});
  endtask

  // Monitors: pop one expected {bit,last} per valid output bit.
  always @(negedge clk) begin
    logic [1:0] e;
    if (bv4) begin
      if (q4.size() == 0) chk("u4_extra_bit", 1, 0);
      else begin
        e = q4.pop_front();
        chk("u4_bit", bit4, e[1]);
        chk("u4_last", last4, e[0]);
      end
    end else if (bit4 || last4) chk("u4_idle_out", {bit4, last4}, 0);
  end

  always @(negedge clk) begin
    logic [1:0] e;
    if (bv8) begin
      if (q8.size() == 0) chk("u8_extra_bit", 1, 0);
      else begin
        e = q8.pop_front();
        chk("u8_bit", bit8, e[1]);
        chk("u8_last", last8, e[0]);
      end
    end else if (bit8 || last8) chk("u8_idle_out", {bit8, last8}, 0);
  end

  always @(negedge clk) begin
    logic [1:0] e;
    if (bv8l) begin
      if (q8l.size() == 0) chk("u8l_extra_bit", 1, 0);
      else begin
        e = q8l.pop_front();
        chk("u8l_bit", bit8l, e[1]);
        chk("u8l_last", last8l, e[0]);
      end
    end else if (bit8l || last8l) chk("u8l_idle_out", {bit8l, last8l}, 0);
  end

  initial begin
    logic [3:0] sr;
    int         hits;
    int         nbits;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    d4 = '0; v4 = 1'b0;
    d8 = '0; v8 = 1'b0;
    d8l = '0; v8l = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_bit", bit8, 0);
    chk("rst_bv", bv8, 0);
    chk("rst_last", last8, 0);
    chk("rst_ready", ready8, 0);
    rst = 1'b1;
    #1;
    chk("rel_ready8", ready8, 1);
    chk("rel_ready4", ready4, 1);
    chk("rel_ready8l", ready8l, 1);

    // Single word, WIDTH=4: 1011 -> 1,0,1,1 with last on 4th
    d4 = 4'b1011;
    v4 = 1'b1;
    q4.push_back(2'b10);
    q4.push_back(2'b00);
    q4.push_back(2'b10);
    q4.push_back(2'b11);
    tick();
    v4 = 1'b0;
    chk("w4_valid_c1", bv4, 1);
    repeat (4) tick();
    chk("w4_idle_bv", bv4, 0);
    chk("w4_idle_bit", bit4, 0);
    chk("w4_idle_ready", ready4, 1);

    // Back-to-back B5, 3C: hold fills at edge 1, drains at edge 8
    d8 = 8'hB5;
    v8 = 1'b1;
    push8(8'hB5);
    chk("b2b_ready_c0", ready8, 1);
    tick();
    chk("b2b_ready_c1", ready8, 1);
    d8 = 8'h3C;
    push8(8'h3C);
    tick();
    v8 = 1'b0;
    for (int c = 2; c <= 16; c++) begin
      chk("b2b_valid", bv8, 1);
      chk("b2b_ready", ready8, 32'(c >= 9));
      tick();
    end
    chk("b2b_idle", bv8, 0);

    // LSB first: 01 -> 1 then seven 0s
    d8l = 8'h01;
    v8l = 1'b1;
    push8l(8'h01);
    tick();
    v8l = 1'b0;
    repeat (8) tick();
    chk("lsb_idle", bv8l, 0);

    // Backpressure: valid held, data changes every cycle.
    // Accepts land on cycles 0, 1, 9, 17 only.
    push8(8'hA0);
    push8(8'hA1);
    push8(8'hA9);
    push8(8'hB1);
    for (int i = 0; i <= 17; i++) begin
      d8 = 8'(8'hA0 + i);
      v8 = 1'b1;
      chk("bp_ready", ready8, 32'(i == 0 || i == 1 || i == 9 || i == 17));
      tick();
    end
    v8 = 1'b0;
    repeat (15) tick();
    chk("bp_idle", bv8, 0);
    chk("bp_drained", q8.size(), 0);

    // Reset mid-word at the 4th bit of FF with 5A buffered
    d8 = 8'hFF;
    v8 = 1'b1;
    repeat (4) q8.push_back(2'b10);
    tick();
    d8 = 8'h5A;
    tick();
    v8 = 1'b0;
    chk("mid_hold_ready", ready8, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", ready8, 0);
    tick();
    chk("mid_rst_bit", bit8, 0);
    chk("mid_rst_bv", bv8, 0);
    chk("mid_rst_last", last8, 0);
    chk("mid_rst_ready2", ready8, 0);
    rst = 1'b1;
    #1;
    chk("mid_rel_ready", ready8, 1);
    nbits = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bv8) nbits++;
    end
    chk("mid_no_remnant", nbits, 0);

    // Downstream 1011 detector on BB MSB-first: hits at bits 3 and 7
    d8 = 8'hBB;
    v8 = 1'b1;
    push8(8'hBB);
    tick();
    v8 = 1'b0;
    sr = '0;
    hits = 0;
    for (int k = 0; k < 8; k++) begin
      chk("det_valid", bv8, 1);
      sr = {sr[2:0], bit8};
      if (sr == 4'b1011) hits++;
      chk("det_hit", 32'(sr == 4'b1011), 32'(k == 3 || k == 7));
      tick();
    end
    chk("det_hits", hits, 2);
    chk("det_idle", bv8, 0);

    repeat (2) tick();
    chk("q4_empty", q4.size(), 0);
    chk("q8_empty", q8.size(), 0);
    chk("q8l_empty", q8l.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = shift MSB first, 0 = shift LSB first.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on posedge clk.
REQ-004 SHALL have port reset_i  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port data_i  input  WIDTH  parallel word to serialize.
REQ-006 SHALL have port valid_i  input  1  data_i holds a valid word.
REQ-007 SHALL have port ready_o  output  1  block can accept a word this cycle.
REQ-008 SHALL have port bit_o  output  1  serial bit stream; feeds the sequence detector in_i.
REQ-009 SHALL have port bit_valid_o  output  1  bit_o carries a real data bit this cycle.
REQ-010 SHALL have port last_o  output  1  bit_o is the final bit of the current word.

Function
REQ-011 SHALL treat a word as accepted on a posedge where reset_i=1, valid_i=1 and ready_o=1; no other condition accepts a word.
REQ-012 SHALL drive ready_o = reset_i AND NOT hold_full, with no combinational dependence on valid_i.
REQ-013 SHALL contain a shift register with bit counter (0..WIDTH-1) and a one-word holding buffer (hold_data, hold_full).
REQ-014 SHALL implement a two-state FSM: IDLE (shifter empty) and SHIFT (shifter holds a word).
REQ-015 SHALL, in IDLE, load an accepted word directly into the shifter at the accepting edge, go to SHIFT and clear the counter.
REQ-016 SHALL present the first bit of a word on bit_o in the cycle immediately after the edge that loads it into the shifter.
REQ-017 SHALL, in SHIFT, advance exactly one bit per clock and increment the counter each edge.
REQ-018 SHALL, in SHIFT with counter < WIDTH-1, store an accepted word in the holding buffer and set hold_full.
REQ-019 SHALL, at the edge where counter = WIDTH-1, reload the shifter from the buffer if hold_full=1 (clearing hold_full), else from an accepted word, else go to IDLE.
REQ-020 SHALL prefer hold_data over data_i on a reload, so words are emitted strictly in acceptance order.
REQ-021 SHALL, when words are continuously available, emit the next word's first bit in the cycle directly after the previous word's last bit (zero-bubble streaming, one word per WIDTH cycles).
REQ-022 SHALL drive bit_valid_o = 1 exactly in SHIFT and drive bit_o = 0 and bit_valid_o = 0 in IDLE.
REQ-023 SHALL assert last_o exactly when in SHIFT with counter = WIDTH-1, one cycle per word.
REQ-024 SHALL drive bit_o, bit_valid_o and last_o from registers only (no combinational path from inputs).
REQ-025 SHALL, when MSB_FIRST=1, emit data bits in order WIDTH-1 down to 0, and when MSB_FIRST=0, in order 0 up to WIDTH-1.
REQ-026 SHALL ignore data_i whenever no acceptance occurs, including when valid_i=1 and ready_o=0.
REQ-027 SHALL never overwrite a full holding buffer; with hold_full=1, ready_o=0 until the buffer drains into the shifter.

Reset
REQ-028 SHALL, on a posedge with reset_i=0, force IDLE, clear the counter, shifter, hold_data and hold_full.
REQ-029 SHALL hold bit_o=0, bit_valid_o=0, last_o=0 and ready_o=0 while reset_i=0.
REQ-030 SHALL discard any in-flight or buffered word on reset mid-operation; no partial word resumes afterwards.
REQ-031 SHALL present ready_o=1 in the first cycle after reset_i returns to 1.

Verification
REQ-032 Bench SHALL check the single-word case: WIDTH=4, MSB_FIRST=1, accept 4'b1011 at edge 0 -> bit_o 1,0,1,1 in cycles 1..4 with bit_valid_o=1; last_o only in cycle 4; IDLE from cycle 5.
REQ-033 Bench SHALL check back-to-back words: WIDTH=8, valid_i held high with 8'hB5 then 8'h3C -> 16 contiguous valid bits 10110101 00111100; ready_o=0 from cycle 2 until the edge where hold drains; no bubble.
REQ-034 Bench SHALL check LSB-first order: MSB_FIRST=0, WIDTH=8, word 8'h01 -> bit_o = 1 then seven 0s; last_o on the eighth bit.
REQ-035 Bench SHALL check backpressure: keep valid_i=1 with hold_full=1 and change data_i each cycle -> only words accepted with ready_o=1 appear, in order, none lost or duplicated.
REQ-036 Bench SHALL check reset mid-word: reset_i=0 for one cycle at bit 3 of 8'hFF with a buffered word -> next cycle outputs all 0, ready_o=0; after release ready_o=1 and no remnant bits are emitted.
REQ-037 Bench SHALL check integration with the downstream detector: stream 8'b1011_1011 MSB-first -> detector flags the 1011 pattern at the expected bit positions.
